// File: rtl/fg_opto_conditioner.sv
// Conditions the asynchronous frame-grabber opto input: synchroniser, glitch filter, edge strobes,
// loss watchdog, and a rising-edge period measurement compiled in only with FG_PERIOD_MEAS_EN.
module fg_opto_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 40,
  parameter int LOSS_TIMEOUT = 4_000_000,
  parameter int PERIOD_W     = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fg_opto_raw,
  output logic                fg_opto,
  output logic                fg_opto_rise,
  output logic                fg_opto_fall,
  output logic                fg_loss,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int               GAP_W    = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [15:0]      FLT_LAST = 16'(FILTER_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(LOSS_TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [15:0]            flt_cnt_r;
  logic [GAP_W-1:0]       gap_cnt_r;
  logic [GAP_W-1:0]       gap_nxt_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Plain flop chain into the clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], fg_opto_raw};
    end
  end

  // Glitch filter: a new level is accepted only after FILTER_LEN consecutive mismatching cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      flt_cnt_r    <= 16'd0;
      fg_opto      <= 1'b0;
      fg_opto_rise <= 1'b0;
      fg_opto_fall <= 1'b0;
    end else if (sync_s != fg_opto) begin
      if (flt_cnt_r == FLT_LAST) begin
        flt_cnt_r    <= 16'd0;
        fg_opto      <= sync_s;
        fg_opto_rise <= sync_s;
        fg_opto_fall <= ~sync_s;
      end else begin
        flt_cnt_r    <= flt_cnt_r + 16'd1;
        fg_opto_rise <= 1'b0;
        fg_opto_fall <= 1'b0;
      end
    end else begin
      flt_cnt_r    <= 16'd0;
      fg_opto_rise <= 1'b0;
      fg_opto_fall <= 1'b0;
    end
  end

  // Gap counter next value: a rise strobe restarts it, otherwise it saturates at the timeout
  always_comb begin
    gap_nxt_s = gap_cnt_r;
    if (fg_opto_rise) begin
      gap_nxt_s = '0;
    end else if (gap_cnt_r != GAP_MAX) begin
      gap_nxt_s = gap_cnt_r + GAP_W'(1);
    end else begin
      gap_nxt_s = gap_cnt_r;
    end
  end

  // fg_loss is registered from the next gap value so it always equals (gap_cnt_r == timeout)
  always_ff @(posedge clock) begin
    if (reset) begin
      gap_cnt_r <= '0;
      fg_loss   <= 1'b0;
    end else begin
      gap_cnt_r <= gap_nxt_s;
      fg_loss   <= (gap_nxt_s == GAP_MAX);
    end
  end

`ifdef FG_PERIOD_MEAS_EN
  typedef enum logic {WAIT_FIRST = 1'b0, MEASURING = 1'b1} per_state_t;

  per_state_t          state_r;
  logic [PERIOD_W-1:0] per_cnt_r;

  // Period FSM; a rise seen while fg_loss is high restarts measurement instead of reporting
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= WAIT_FIRST;
      per_cnt_r    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state_r)
        WAIT_FIRST: begin
          if (fg_opto_rise) begin
            per_cnt_r <= PERIOD_W'(1);
            state_r   <= MEASURING;
          end
        end
        MEASURING: begin
          if (fg_opto_rise && !fg_loss) begin
            period       <= per_cnt_r;
            period_valid <= 1'b1;
            per_cnt_r    <= PERIOD_W'(1);
          end else if (fg_opto_rise) begin
            per_cnt_r <= PERIOD_W'(1);
          end else if (fg_loss) begin
            state_r <= WAIT_FIRST;
          end else if (per_cnt_r != '1) begin
            per_cnt_r <= per_cnt_r + PERIOD_W'(1);
          end
        end
        default: begin
          state_r <= WAIT_FIRST;
        end
      endcase
    end
  end
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule
